apb_to_ahbl: RTL and testbench
==============================

Name: apb_to_ahbl

Overview:
Bridge that accepts APB transfers as a slave and issues each one as a single AHB-Lite transfer as a master. It lets APB-only initiators (debug transport, simple DMA-less peripherals, test harnesses) reach the AHB-Lite system fabric. It handles one transfer at a time with no buffering beyond a single outstanding request. AHB-Lite error responses are reported as APB PSLVERR.

Parameters:
W_PADDR, 16, APB address width
W_HADDR, 32, AHB-Lite address width; must be >= W_PADDR
W_DATA, 32, data width on both sides; 32 only (HSIZE fixed to word)
HADDR_BASE, 32'h0, W_HADDR-bit base OR'd onto the zero-extended PADDR; low W_PADDR bits must be zero

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
apbs_psel  in  1  APB select
apbs_penable  in  1  APB enable (access phase)
apbs_pwrite  in  1  APB write
apbs_paddr  in  W_PADDR  APB address
apbs_pwdata  in  W_DATA  APB write data
apbs_pready  out  1  APB ready
apbs_prdata  out  W_DATA  APB read data
apbs_pslverr  out  1  APB error
ahblm_haddr  out  W_HADDR  AHB address
ahblm_hwrite  out  1  AHB write
ahblm_htrans  out  2  AHB transfer type: IDLE (00) or NONSEQ (10) only
ahblm_hsize  out  3  constant 3'b010
ahblm_hburst  out  3  constant 3'b000 (SINGLE)
ahblm_hprot  out  4  constant 4'b0011
ahblm_hmastlock  out  1  constant 0
ahblm_hwdata  out  W_DATA  AHB write data
ahblm_hready  in  1  AHB ready
ahblm_hresp  in  1  AHB error response
ahblm_hrdata  in  W_DATA  AHB read data

Behaviour:
- Reset (rst_n low at a clk edge): state S_IDLE. All outputs and registers are 0, including pready, pslverr, prdata, haddr, hwrite, hwdata and htrans (IDLE).
- All outputs are decoded from registers only. There are no combinational input-to-output paths.
- FSM states and transitions:
  - S_IDLE: htrans=IDLE, pready=0. If psel && !penable (APB setup), latch haddr = HADDR_BASE | paddr, latch hwrite = pwrite and hwdata = pwdata, then go to S_ADDR. penable without a preceding setup is ignored.
  - S_ADDR: htrans=NONSEQ with the latched haddr and hwrite. If hready, go to S_DATA; otherwise hold in S_ADDR with all address-phase signals stable.
  - S_DATA: htrans=IDLE, hwdata held. If hready, latch prdata = hrdata (reads only; writes leave prdata unchanged), latch pslverr = hresp, then go to S_RESP. While !hready, stay in S_DATA; this includes the first cycle of a two-cycle AHB error (hresp=1, hready=0).
  - S_RESP: pready=1 for exactly one cycle, with prdata and pslverr valid. Then go to S_IDLE. pslverr is cleared on leaving S_RESP.
- pready is 0 in every state except S_RESP, so the APB setup phase never completes early.
- Minimum latency, zero AHB wait states: setup edge, then S_ADDR, S_DATA and S_RESP. pready is high on the 3rd access-phase cycle, for 4 APB cycles in total.
- Each AHB wait state (hready=0) in S_ADDR or S_DATA adds exactly one APB cycle.
- Back-to-back transfers: a new setup in the cycle immediately after S_RESP is sampled in S_IDLE. No dead cycle is required beyond that.
- AHB error response: pslverr=1 is returned with pready. prdata is unchanged on error. The bridge issues no further AHB transfer until a new APB setup arrives.
- Illegal APB behaviour: if psel drops mid-transfer, the AHB transfer still completes, the FSM still passes through S_RESP and then returns to S_IDLE. No hang.
- Reset mid-transfer: the FSM returns to S_IDLE and htrans=IDLE on the reset edge, and the in-flight AHB data phase is abandoned. The system resets both sides together.
- Address arithmetic: paddr is zero-extended to W_HADDR and OR'd with HADDR_BASE. There is no addition and no carry.

Test Plan:
- Single write, zero wait: paddr=16'h0040, pwdata=32'hDEADBEEF, HADDR_BASE=32'h4000_0000 -> one NONSEQ cycle with haddr=32'h4000_0040, hwrite=1; hwdata=DEADBEEF in the next cycle; pready=1 on the 3rd access cycle; pslverr=0.
- Single read, 2 AHB data wait states: hrdata=32'h1234_5678 on the hready cycle -> pready on the 5th access cycle, prdata=12345678, pslverr=0.
- AHB error: hresp=1/hready=0, then hresp=1/hready=1 -> pready=1 with pslverr=1; prdata unchanged; the next transfer completes with pslverr=0.
- Address-phase stall: hready=0 for 3 cycles in S_ADDR -> htrans, haddr and hwrite held stable throughout; exactly one NONSEQ accepted.
- Back-to-back write then read, with setup immediately after pready -> both complete with no lost or duplicated AHB transfer and correct data.
- Reset asserted in S_DATA -> next cycle htrans=IDLE, pready=0 and all outputs 0; a subsequent transfer completes normally.

Source files
------------

// File: rtl/apb_to_ahbl.sv
// APB slave to AHB-Lite master bridge: each APB transfer becomes one single-beat
// AHB-Lite word transfer, with AHB error responses returned as PSLVERR.
module apb_to_ahbl #(
   parameter int unsigned        W_PADDR    = 16,
   parameter int unsigned        W_HADDR    = 32,
   parameter int unsigned        W_DATA     = 32,
   parameter logic [W_HADDR-1:0] HADDR_BASE = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               apbs_psel,
   input  logic               apbs_penable,
   input  logic               apbs_pwrite,
   input  logic [W_PADDR-1:0] apbs_paddr,
   input  logic [W_DATA-1:0]  apbs_pwdata,
   output logic               apbs_pready,
   output logic [W_DATA-1:0]  apbs_prdata,
   output logic               apbs_pslverr,
   output logic [W_HADDR-1:0] ahblm_haddr,
   output logic               ahblm_hwrite,
   output logic [1:0]         ahblm_htrans,
   output logic [2:0]         ahblm_hsize,
   output logic [2:0]         ahblm_hburst,
   output logic [3:0]         ahblm_hprot,
   output logic               ahblm_hmastlock,
   output logic [W_DATA-1:0]  ahblm_hwdata,
   input  logic               ahblm_hready,
   input  logic               ahblm_hresp,
   input  logic [W_DATA-1:0]  ahblm_hrdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t state;

   assign ahblm_hsize     = 3'b010;
   assign ahblm_hburst    = 3'b000;
   assign ahblm_hprot     = 4'b0011;
   assign ahblm_hmastlock = 1'b0;

   // Only an APB setup phase starts a transfer; a stray penable in idle is ignored.
   // Inputs outside the current state's concern are deliberately not looked at, so a
   // master dropping psel mid-transfer cannot stall the AHB side.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         apbs_pready  <= 1'b0;
         apbs_prdata  <= '0;
         apbs_pslverr <= 1'b0;
         ahblm_haddr  <= '0;
         ahblm_hwrite <= 1'b0;
         ahblm_htrans <= HTRANS_IDLE;
         ahblm_hwdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (apbs_psel && !apbs_penable) begin
                  ahblm_haddr  <= HADDR_BASE | W_HADDR'(apbs_paddr);
                  ahblm_hwrite <= apbs_pwrite;
                  ahblm_hwdata <= apbs_pwdata;
                  ahblm_htrans <= HTRANS_NONSEQ;
                  state        <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (ahblm_hready) begin
                  ahblm_htrans <= HTRANS_IDLE;
                  state        <= S_DATA;
               end
            end
            S_DATA: begin
               // The first half of a two-cycle error has hready low and simply waits here.
               if (ahblm_hready) begin
                  if (!ahblm_hwrite && !ahblm_hresp) begin
                     apbs_prdata <= ahblm_hrdata;
                  end
                  apbs_pslverr <= ahblm_hresp;
                  apbs_pready  <= 1'b1;
                  state        <= S_RESP;
               end
            end
            S_RESP: begin
               apbs_pready  <= 1'b0;
               apbs_pslverr <= 1'b0;
               state        <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Randomized self-checking bench for apb_to_ahbl: the bench plays APB master and a
// scripted AHB-Lite slave backed by a word memory, and predicts each transfer's timeline.
module tb_apb_to_ahbl;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        apbs_psel;
   logic        apbs_penable;
   logic        apbs_pwrite;
   logic [15:0] apbs_paddr;
   logic [31:0] apbs_pwdata;
   logic        apbs_pready;
   logic [31:0] apbs_prdata;
   logic        apbs_pslverr;
   logic [31:0] ahblm_haddr;
   logic        ahblm_hwrite;
   logic [1:0]  ahblm_htrans;
   logic [2:0]  ahblm_hsize;
   logic [2:0]  ahblm_hburst;
   logic [3:0]  ahblm_hprot;
   logic        ahblm_hmastlock;
   logic [31:0] ahblm_hwdata;
   logic        ahblm_hready;
   logic        ahblm_hresp;
   logic [31:0] ahblm_hrdata;

   int vectors    = 0;
   int miscompares = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] last_prdata;

   apb_to_ahbl #(
      .W_PADDR   (16),
      .W_HADDR   (32),
      .W_DATA    (32),
      .HADDR_BASE(BASE)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .apbs_psel      (apbs_psel),
      .apbs_penable   (apbs_penable),
      .apbs_pwrite    (apbs_pwrite),
      .apbs_paddr     (apbs_paddr),
      .apbs_pwdata    (apbs_pwdata),
      .apbs_pready    (apbs_pready),
      .apbs_prdata    (apbs_prdata),
      .apbs_pslverr   (apbs_pslverr),
      .ahblm_haddr    (ahblm_haddr),
      .ahblm_hwrite   (ahblm_hwrite),
      .ahblm_htrans   (ahblm_htrans),
      .ahblm_hsize    (ahblm_hsize),
      .ahblm_hburst   (ahblm_hburst),
      .ahblm_hprot    (ahblm_hprot),
      .ahblm_hmastlock(ahblm_hmastlock),
      .ahblm_hwdata   (ahblm_hwdata),
      .ahblm_hready   (ahblm_hready),
      .ahblm_hresp    (ahblm_hresp),
      .ahblm_hrdata   (ahblm_hrdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One APB transfer. The AHB slave inserts aw address-phase and dw data-phase wait
   // states; an error uses the two-cycle response, so err implies dw >= 1.
   task automatic applyStimulus(input bit wr, input logic [15:0] pa, input logic [31:0] wd,
                                input int aw, input int dw, input bit err, input bit drop_sel);
      logic [31:0] exp_addr;
      logic [31:0] rd;
      logic [31:0] exp_pr;
      int          last;
      bit          exp_nonseq;
      exp_addr = BASE | {16'h0000, pa};
      rd       = mem.exists(exp_addr) ? mem[exp_addr] : $urandom;
      exp_pr   = (!wr && !err) ? rd : last_prdata;
      last     = aw + dw + 3;

      @(posedge clk); #1;
      apbs_psel    = 1'b1;
      apbs_penable = 1'b0;
      apbs_pwrite  = wr;
      apbs_paddr   = pa;
      apbs_pwdata  = wd;
      ahblm_hready = 1'b1;
      ahblm_hresp  = 1'b0;
      @(negedge clk);
      checkOutput("setup_htrans", ahblm_htrans, 2'b00);
      checkOutput("setup_pready", apbs_pready, 1'b0);
      checkOutput("setup_pslverr", apbs_pslverr, 1'b0);

      for (int c = 1; c <= last; c++) begin
         @(posedge clk); #1;
         apbs_penable = 1'b1;
         apbs_psel    = drop_sel ? (c == 1) : 1'b1;
         ahblm_hrdata = $urandom;
         ahblm_hresp  = 1'b0;
         if (c <= aw) begin
            ahblm_hready = 1'b0;
         end else if (c == aw + 1) begin
            ahblm_hready = 1'b1;
         end else if (c <= aw + 1 + dw) begin
            ahblm_hready = 1'b0;
            ahblm_hresp  = err && (c == aw + 1 + dw);
         end else if (c == aw + dw + 2) begin
            ahblm_hready = 1'b1;
            ahblm_hresp  = err;
            ahblm_hrdata = rd;
         end else begin
            ahblm_hready = 1'b1;
         end
         @(negedge clk);
         exp_nonseq = (c <= aw + 1);
         checkOutput("htrans", ahblm_htrans, exp_nonseq ? 2'b10 : 2'b00);
         if (exp_nonseq) begin
            checkOutput("haddr", ahblm_haddr, exp_addr);
            checkOutput("hwrite", ahblm_hwrite, wr);
         end
         if (wr && c >= aw + 2 && c <= aw + dw + 2) begin
            checkOutput("hwdata", ahblm_hwdata, wd);
         end
         checkOutput("pready", apbs_pready, c == last);
         if (c == last) begin
            checkOutput("prdata", apbs_prdata, exp_pr);
            checkOutput("pslverr", apbs_pslverr, err);
         end
      end

      last_prdata = exp_pr;
      if (wr && !err) begin
         mem[exp_addr] = wd;
      end
   endtask

   // Idle cycles with psel toggling but penable high, so no valid setup is ever offered.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         apbs_psel    = 1'($urandom_range(0, 1));
         apbs_penable = 1'b1;
         ahblm_hready = 1'b1;
         ahblm_hresp  = 1'b0;
         @(negedge clk);
         checkOutput("idle_htrans", ahblm_htrans, 2'b00);
         checkOutput("idle_pready", apbs_pready, 1'b0);
         checkOutput("idle_pslverr", apbs_pslverr, 1'b0);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pready"}, apbs_pready, 1'b0);
      checkOutput({tag, "_prdata"}, apbs_prdata, 32'h0);
      checkOutput({tag, "_pslverr"}, apbs_pslverr, 1'b0);
      checkOutput({tag, "_haddr"}, ahblm_haddr, 32'h0);
      checkOutput({tag, "_hwrite"}, ahblm_hwrite, 1'b0);
      checkOutput({tag, "_htrans"}, ahblm_htrans, 2'b00);
      checkOutput({tag, "_hwdata"}, ahblm_hwdata, 32'h0);
   endtask

   task automatic resetMidTransfer();
      @(posedge clk); #1;
      apbs_psel    = 1'b1;
      apbs_penable = 1'b0;
      apbs_pwrite  = 1'b1;
      apbs_paddr   = 16'h0080;
      apbs_pwdata  = 32'hCAFE_F00D;
      ahblm_hready = 1'b1;
      ahblm_hresp  = 1'b0;
      @(posedge clk); #1;
      apbs_penable = 1'b1;
      @(posedge clk); #1;
      ahblm_hready = 1'b0;
      @(negedge clk);
      checkOutput("rst_pre_htrans", ahblm_htrans, 2'b00);
      checkOutput("rst_pre_hwdata", ahblm_hwdata, 32'hCAFE_F00D);
      @(posedge clk); #1;
      rst_n        = 1'b0;
      apbs_psel    = 1'b0;
      apbs_penable = 1'b0;
      @(posedge clk); #1;
      rst_n        = 1'b1;
      ahblm_hready = 1'b1;
      @(negedge clk);
      checkAllZero("midrst");
      last_prdata = 32'h0;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int aw;
      int dw;
      bit err;
      rst_n        = 1'b0;
      apbs_psel    = 1'b0;
      apbs_penable = 1'b0;
      apbs_pwrite  = 1'b0;
      apbs_paddr   = '0;
      apbs_pwdata  = '0;
      ahblm_hready = 1'b1;
      ahblm_hresp  = 1'b0;
      ahblm_hrdata = '0;
      last_prdata  = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      checkOutput("hsize", ahblm_hsize, 3'b010);
      checkOutput("hburst", ahblm_hburst, 3'b000);
      checkOutput("hprot", ahblm_hprot, 4'b0011);
      checkOutput("hmastlock", ahblm_hmastlock, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idleCycles(2);

      applyStimulus(1'b1, 16'h0040, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
      idleCycles(1);
      mem[BASE | 32'h0000_0044] = 32'h1234_5678;
      applyStimulus(1'b0, 16'h0044, 32'h0, 0, 2, 1'b0, 1'b0);
      idleCycles(1);
      applyStimulus(1'b0, 16'h0048, 32'h0, 0, 1, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0040, 32'h0, 0, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0050, 32'h0BAD_F00D, 3, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0060, 32'hA5A5_5A5A, 0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0060, 32'h0, 0, 0, 1'b0, 1'b0);
      resetMidTransfer();
      applyStimulus(1'b0, 16'h0050, 32'h0, 1, 1, 1'b0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         aw  = $urandom_range(0, 3);
         dw  = $urandom_range(0, 3);
         err = ($urandom_range(0, 7) == 0);
         if (err && dw == 0) dw = 1;
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63) << 2), $urandom,
                       aw, dw, err, ($urandom_range(0, 7) == 0));
         idleCycles($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
